// File: rtl/gusn_pkg.sv
// rtl/gusn_pkg.sv - shared loss/gradient types and width-generic saturation helpers
package gusn_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_F, CALC, DONE} loss_state_t;

    // Helpers work on a wide signed carrier; w selects the target signed width.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic signed [63:0] sat_pos(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (x < 64'sd0)
            return 64'sd0;
        else if (x > hi)
            return hi;
        else
            return x;
    endfunction

endpackage

// File: rtl/fx_sq_sat.sv
// rtl/fx_sq_sat.sv - saturated fixed-point difference and its saturated square
module fx_sq_sat
    import gusn_pkg::*;
#(
    parameter int NUM_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic signed [NUM_W-1:0] a,
    input  logic signed [NUM_W-1:0] b,
    output logic signed [NUM_W-1:0] d,
    output logic        [NUM_W-1:0] sq
);

    logic signed [NUM_W:0]     diff;
    logic signed [2*NUM_W-1:0] prod;
    logic signed [2*NUM_W-1:0] prod_sh;

    always_comb begin
        diff    = (NUM_W+1)'(a) - (NUM_W+1)'(b);
        d       = NUM_W'(sat_signed(64'(diff), NUM_W));
        prod    = d * d;
        prod_sh = prod >>> FRAC_W;
        sq      = NUM_W'(sat_pos(64'(prod_sh), NUM_W));
    end

endmodule

// File: rtl/loss_stage.sv
// rtl/loss_stage.sv - per-output error and saturating sum-of-squares loss, then back-prop launch
module loss_stage
    import gusn_pkg::*;
#(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int OUTPUTS = 1,
    parameter int NUM_W   = INT_W + FRAC_W
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic                            enable,
    input  logic [OUTPUTS-1:0][NUM_W-1:0]   outputs_f,
    input  logic [OUTPUTS-1:0][NUM_W-1:0]   targets,
    input  logic                            ready_f_in,
    input  logic                            start,
    output logic [OUTPUTS-1:0][NUM_W-1:0]   errors_b,
    output logic [NUM_W-1:0]                loss,
    output logic                            loss_valid,
    output logic                            ready_out,
    output logic                            start_b
);

    localparam int CW = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    loss_state_t                    state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [NUM_W-1:0]               acc_q, acc_d;
    logic [OUTPUTS-1:0][NUM_W-1:0]  err_q, err_d;
    logic [NUM_W-1:0]               loss_q, loss_d;
    logic                           valid_q, valid_d;

    logic signed [NUM_W-1:0]        cur_out, cur_tgt, d_val;
    logic [NUM_W-1:0]               sq_val, acc_next;
    logic [NUM_W:0]                 acc_sum;

    always_comb begin
        cur_out = '0;
        cur_tgt = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (cnt_q == CW'(i)) begin
                cur_out = outputs_f[i];
                cur_tgt = targets[i];
            end
        end
    end

    fx_sq_sat #(.NUM_W(NUM_W), .FRAC_W(FRAC_W)) u_sq (
        .a  (cur_out),
        .b  (cur_tgt),
        .d  (d_val),
        .sq (sq_val)
    );

    // Both operands are already clamped to the positive range, so one extra bit cannot overflow.
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, sq_val};
        acc_next = NUM_W'(sat_pos(64'(acc_sum), NUM_W));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        loss_d  = loss_q;
        valid_d = valid_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        err_d   = '0;
                        valid_d = 1'b0;
                        state_d = WAIT_F;
                    end
                end
                WAIT_F: begin
                    if (ready_f_in)
                        state_d = CALC;
                end
                CALC: begin
                    for (int i = 0; i < OUTPUTS; i++) begin
                        if (cnt_q == CW'(i))
                            err_d[i] = d_val;
                    end
                    acc_d = acc_next;
                    if (cnt_q == CW'(OUTPUTS - 1)) begin
                        loss_d  = acc_next;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= '0;
            loss_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            loss_q  <= loss_d;
            valid_q <= valid_d;
        end
    end

    assign errors_b   = err_q;
    assign loss       = loss_q;
    assign loss_valid = valid_q;
    assign ready_out  = (state_q == IDLE);
    assign start_b    = (state_q == DONE);

endmodule

// File: tb/tb_loss_stage.sv
// tb/tb_loss_stage.sv - table-driven and scoreboarded bench for loss_stage
module tb_loss_stage;

    logic clk = 1'b0;
    logic nreset = 1'b1;
    logic enable = 1'b1;
    logic ready_f_in = 1'b0;
    logic start = 1'b0;
    logic [2:0][15:0] outputs_f = '0;
    logic [2:0][15:0] targets = '0;
    logic [2:0][15:0] errors_b;
    logic [15:0] loss;
    logic loss_valid, ready_out, start_b;

    logic ready1 = 1'b0;
    logic start1 = 1'b0;
    logic [0:0][15:0] o1 = '0;
    logic [0:0][15:0] t1 = '0;
    logic [0:0][15:0] e1;
    logic [15:0] loss1;
    logic lv1, ro1, sb1;

    always #5 clk = ~clk;

    loss_stage #(.INT_W(8), .FRAC_W(8), .OUTPUTS(3)) dut (
        .clk(clk), .nreset(nreset), .enable(enable), .outputs_f(outputs_f),
        .targets(targets), .ready_f_in(ready_f_in), .start(start),
        .errors_b(errors_b), .loss(loss), .loss_valid(loss_valid),
        .ready_out(ready_out), .start_b(start_b)
    );

    loss_stage #(.INT_W(8), .FRAC_W(8), .OUTPUTS(1)) dut1 (
        .clk(clk), .nreset(nreset), .enable(enable), .outputs_f(o1),
        .targets(t1), .ready_f_in(ready1), .start(start1),
        .errors_b(e1), .loss(loss1), .loss_valid(lv1),
        .ready_out(ro1), .start_b(sb1)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0][15:0] o;
        logic [2:0][15:0] t;
        logic [2:0][15:0] e;
        logic [15:0]      l;
    } vec_t;

    typedef struct {
        logic [2:0][15:0] e;
        logic [15:0]      l;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    function automatic vec_t mk(input logic [15:0] o0, o1_, o2, t0, t1_, t2,
                                input logic [15:0] x0, x1, x2, l);
        vec_t v;
        v.o = {o2, o1_, o0};
        v.t = {t2, t1_, t0};
        v.e = {x2, x1, x0};
        v.l = l;
        return v;
    endfunction

    always @(negedge clk) begin
        if (start_b === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb unexpected start_b: got 1 expected 0");
            end else begin
                mon_x = sb_q.pop_front();
                chk("sb errors_b", errors_b, mon_x.e);
                chk("sb loss", loss, mon_x.l);
                chk("sb loss_valid", loss_valid, 1);
            end
        end
    end

    task automatic run(input vec_t v, input int exp_lat);
        int lat;
        exp_t x;
        outputs_f = v.o;
        targets = v.t;
        ready_f_in = 1'b1;
        start = 1'b1;
        x.e = v.e;
        x.l = v.l;
        sb_q.push_back(x);
        @(posedge clk); #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (start_b) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, exp_lat);
        @(posedge clk); #1;
        chk("ready after done", ready_out, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("loss hold", loss, v.l);
        chk("errors hold", errors_b, v.e);
    endtask

    vec_t vecs[6];
    int p0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(16'h0180, 16'h0000, 16'hFF00, 16'h0100, 16'h0100, 16'hFF00,
                     16'h0080, 16'hFF00, 16'h0000, 16'h0140);
        vecs[1] = mk(16'h7FFF, 16'h0100, 16'h0200, 16'h8000, 16'h0100, 16'h0200,
                     16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF);
        vecs[2] = mk(16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000,
                     16'h8000, 16'h0000, 16'h0000, 16'h7FFF);
        vecs[3] = mk(16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000,
                     16'h0040, 16'h0040, 16'h0040, 16'h0030);
        vecs[4] = mk(16'h0B00, 16'h0B00, 16'h0B00, 16'h0000, 16'h0000, 16'h0000,
                     16'h0B00, 16'h0B00, 16'h0B00, 16'h7FFF);
        vecs[5] = mk(16'hFF80, 16'h0000, 16'h0100, 16'h0000, 16'hFF80, 16'h0100,
                     16'hFF80, 16'h0080, 16'h0000, 16'h0080);

        #1 nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready_out", ready_out, 1);
        chk("reset start_b", start_b, 0);
        chk("reset loss", loss, 0);
        chk("reset loss_valid", loss_valid, 0);
        chk("reset errors_b", errors_b, 0);
        chk("reset ready_out1", ro1, 1);
        nreset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run(vecs[i], 4);

        // Late ready_f_in: WAIT_F must stretch until it is seen.
        outputs_f = vecs[0].o;
        targets = vecs[0].t;
        ready_f_in = 1'b0;
        start = 1'b1;
        sb_q.push_back('{vecs[0].e, vecs[0].l});
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("timing start_b k=%0d", k), start_b, (k == 8));
            chk($sformatf("timing ready_out k=%0d", k), ready_out, (k == 9));
            if (k == 0) chk("timing loss_valid cleared", loss_valid, 0);
            if (k == 8) chk("timing loss_valid set", loss_valid, 1);
            if (k == 4) ready_f_in = 1'b1;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;

        // Enable gap mid-CALC plus an ignored start.
        p0 = pulses;
        start = 1'b1;
        sb_q.push_back('{vecs[0].e, vecs[0].l});
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("enable start_b k=%0d", k), start_b, (k == 8));
            chk($sformatf("enable ready_out k=%0d", k), ready_out, (k >= 9));
            if (k == 1) enable = 1'b0;
            if (k == 5) enable = 1'b1;
            if (k == 6) start = 1'b1;
            if (k == 7) start = 1'b0;
        end
        chk("enable single pulse", pulses - p0, 1);
        chk("enable loss", loss, 16'h0140);

        // Async reset with cnt=1 in CALC.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid-run errors_b[0]", errors_b[0], 16'h0080);
        chk("mid-run ready_out", ready_out, 0);
        nreset = 1'b0;
        #1;
        chk("async errors_b", errors_b, 0);
        chk("async loss", loss, 0);
        chk("async loss_valid", loss_valid, 0);
        chk("async ready_out", ready_out, 1);
        chk("async start_b", start_b, 0);
        p0 = pulses;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no start_b after reset", pulses - p0, 0);
        run(vecs[0], 4);

        // Single-output instance.
        o1[0] = 16'h0200;
        t1[0] = 16'h0000;
        ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("one start_b k=%0d", k), sb1, (k == 2));
            if (k == 2) begin
                chk("one errors_b", e1[0], 16'h0200);
                chk("one loss", loss1, 16'h0400);
                chk("one loss_valid", lv1, 1);
            end
        end
        chk("scoreboard drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
